// File: rtl/ajuste_porcentaje_pulsadores.sv
// ajuste_porcentaje_pulsadores: push-button controlled duty-cycle value (0..100) with debounce and auto-repeat
// Ports:
//    CLK          system clock
//    RST_n        synchronous active-low reset
//    boton_subir  raw up button, active-low, asynchronous
//    boton_bajar  raw down button, active-low, asynchronous
//    paso_grande  1 = step PASO_GRANDE, 0 = step 1, sampled on every step
//    porcentaje   registered duty cycle 0..100
//    actualizado  one-cycle strobe, high in the cycle porcentaje takes a new value
module ajuste_porcentaje_pulsadores #(
   parameter int T_DEBOUNCE   = 500_000,
   parameter int T_RETARDO    = 25_000_000,
   parameter int T_REPETICION = 5_000_000,
   parameter int PORC_INICIAL = 50,
   parameter int PASO_GRANDE  = 10
) (
   input  logic       CLK,
   input  logic       RST_n,
   input  logic       boton_subir,
   input  logic       boton_bajar,
   input  logic       paso_grande,
   output logic [6:0] porcentaje,
   output logic       actualizado
);
   localparam int WD   = $clog2(T_DEBOUNCE + 1);
   localparam int TMAX = (T_RETARDO > T_REPETICION) ? T_RETARDO : T_REPETICION;
   localparam int WT   = $clog2(TMAX + 1);
   // An out-of-range initial value is clamped rather than allowed to exceed 100.
   localparam logic [6:0]    INI     = 7'((PORC_INICIAL > 100) ? 100 : PORC_INICIAL);
   localparam logic [WD-1:0] DB_FIN  = WD'(T_DEBOUNCE - 1);
   localparam logic [WT-1:0] RET_FIN = WT'(T_RETARDO - 1);
   localparam logic [WT-1:0] REP_FIN = WT'(T_REPETICION - 1);
   localparam logic [7:0]    PASO_G  = 8'(PASO_GRANDE);

   typedef enum logic [1:0] {NINGUNA, SUBIR, BAJAR} dir_t;
   typedef enum logic [1:0] {REPOSO, RETARDO, REPETICION} estado_t;

   // Index 0 is the up button, index 1 the down button; all kept active-low.
   logic [1:0]    raw, sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d;
   logic [WD-1:0] cnt_q [2];
   logic [WD-1:0] cnt_d [2];
   dir_t          dir, dir_q, dir_d;
   estado_t       estado_q, estado_d;
   logic [WT-1:0] t_q, t_d;
   logic [6:0]    porc_q, porc_d, nuevo;
   logic          act_q, act_d, paso_ev;
   logic [7:0]    paso, suma;
   logic signed [8:0] resta;

   assign raw = {boton_bajar, boton_subir};

   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      db_d    = db_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == DB_FIN) db_d[i] = sync2_q[i];
            else cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // Both buttons pressed together cancel each other out.
   assign dir = (!db_q[0] && db_q[1]) ? SUBIR : (!db_q[1] && db_q[0]) ? BAJAR : NINGUNA;

   always_comb begin
      estado_d = estado_q;
      dir_d    = dir_q;
      t_d      = t_q;
      paso_ev  = 1'b0;
      if (dir == NINGUNA) begin
         estado_d = REPOSO;
         t_d      = '0;
      end else if (estado_q == REPOSO || dir != dir_q) begin
         // A fresh press, or a direct reversal, steps at once and restarts the hold delay.
         paso_ev  = 1'b1;
         t_d      = '0;
         estado_d = RETARDO;
         dir_d    = dir;
      end else if (t_q == ((estado_q == RETARDO) ? RET_FIN : REP_FIN)) begin
         paso_ev  = 1'b1;
         t_d      = '0;
         estado_d = REPETICION;
      end else begin
         t_d = t_q + 1'b1;
      end
   end

   always_comb begin
      paso   = paso_grande ? PASO_G : 8'd1;
      suma   = {1'b0, porc_q} + paso;
      resta  = $signed({2'b00, porc_q}) - $signed({1'b0, paso});
      nuevo  = (dir == SUBIR) ? ((suma > 8'd100) ? 7'd100 : suma[6:0])
                              : ((resta < 0) ? 7'd0 : resta[6:0]);
      porc_d = paso_ev ? nuevo : porc_q;
      act_d  = paso_ev && (nuevo != porc_q);
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         sync1_q  <= '1;
         sync2_q  <= '1;
         db_q     <= '1;
         cnt_q    <= '{default: '0};
         estado_q <= REPOSO;
         dir_q    <= NINGUNA;
         t_q      <= '0;
         porc_q   <= INI;
         act_q    <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         db_q     <= db_d;
         cnt_q    <= cnt_d;
         estado_q <= estado_d;
         dir_q    <= dir_d;
         t_q      <= t_d;
         porc_q   <= porc_d;
         act_q    <= act_d;
      end
   end

   assign porcentaje  = porc_q;
   assign actualizado = act_q;
endmodule

// File: tb/tb_ajuste_porcentaje_pulsadores.sv
// tb_ajuste_porcentaje_pulsadores: scoreboard bench with a behavioural model of the button-driven percentage
module tb_ajuste_porcentaje_pulsadores;
   localparam int T_DB = 4, T_RET = 20, T_REP = 5, P_INI = 50, P_G = 10;

   logic       clk = 1'b0;
   logic       rst_n, up, dn, pg;
   logic [6:0] porcentaje;
   logic       actualizado;

   int checks = 0, errors = 0;
   int exp_q[$];

   // Behavioural model state: synced samples, debounced levels, run lengths, hold time.
   int ms1[2], ms2[2], mdb[2], mrun[2];
   int mprev, mheld, mp, md, mpaso, mnv;
   bit mstep;
   int e;

   ajuste_porcentaje_pulsadores #(
      .T_DEBOUNCE(T_DB), .T_RETARDO(T_RET), .T_REPETICION(T_REP),
      .PORC_INICIAL(P_INI), .PASO_GRANDE(P_G)
   ) dut (
      .CLK(clk), .RST_n(rst_n), .boton_subir(up), .boton_bajar(dn),
      .paso_grande(pg), .porcentaje(porcentaje), .actualizado(actualizado)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            ms1 = '{1, 1}; ms2 = '{1, 1}; mdb = '{1, 1}; mrun = '{0, 0};
            mprev = 0; mheld = 0; mp = P_INI;
         end else begin
            md = (mdb[0] == 0 && mdb[1] == 1) ? 1 : (mdb[1] == 0 && mdb[0] == 1) ? 2 : 0;
            mstep = 1'b0;
            if (md != 0) begin
               if (md != mprev) begin
                  mstep = 1'b1;
                  mheld = 0;
               end else begin
                  mheld++;
                  if (mheld == T_RET || (mheld > T_RET && (mheld - T_RET) % T_REP == 0)) mstep = 1'b1;
               end
            end
            mprev = md;
            if (mstep) begin
               mpaso = pg ? P_G : 1;
               mnv = (md == 1) ? ((mp + mpaso > 100) ? 100 : mp + mpaso)
                               : ((mp - mpaso < 0) ? 0 : mp - mpaso);
               if (mnv != mp) begin
                  exp_q.push_back(mnv);
                  mp = mnv;
               end
            end
            for (int b = 0; b < 2; b++) begin
               if (ms2[b] != mdb[b]) begin
                  mrun[b]++;
                  if (mrun[b] == T_DB) begin
                     mdb[b] = ms2[b];
                     mrun[b] = 0;
                  end
               end else mrun[b] = 0;
            end
            ms2 = ms1;
            ms1[0] = int'(up);
            ms1[1] = int'(dn);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (actualizado) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL strobe_spurious got porcentaje=%0d with no change expected", porcentaje);
            end else begin
               e = exp_q.pop_front();
               if (porcentaje !== 7'(e)) begin
                  errors++;
                  $display("FAIL strobe_value got %0d expected %0d", porcentaje, e);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string name, input int exp);
      checks++;
      if (porcentaje !== 7'(exp)) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, porcentaje, exp);
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (exp_q.size() != 0 || porcentaje !== 7'(mp)) begin
         errors++;
         $display("FAIL %s got %0d expected %0d pending_strobes=%0d", name, porcentaje, mp, exp_q.size());
      end
   endtask

   task automatic press(input bit sube, input bit big, input int hold);
      pg = big;
      if (sube) up = 1'b0;
      else dn = 1'b0;
      tick(hold);
      up = 1'b1;
      dn = 1'b1;
      tick(12);
      check_idle("press");
   endtask

   initial begin
      rst_n = 1'b0; up = 1'b1; dn = 1'b1; pg = 1'b0;
      tick(2);
      check_val("reset_value", 50);
      checks++;
      if (actualizado !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobe got %0b expected 0", actualizado);
      end
      rst_n = 1'b1;
      tick(50);
      check_val("idle", 50);
      check_idle("idle_model");

      up = 1'b0;
      tick(6);
      check_val("latency_before", 50);
      tick(1);
      check_val("latency_step", 51);
      tick(3);
      up = 1'b1;
      tick(12);
      check_idle("single_press");

      up = 1'b0;
      tick(60);
      up = 1'b1;
      tick(15);
      check_idle("auto_repeat");

      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check_val("reset_again", 50);
      repeat (4) press(1'b1, 1'b1, 10);
      repeat (5) press(1'b1, 1'b0, 10);
      check_val("value_95", 95);
      press(1'b1, 1'b1, 10);
      check_val("sat_high", 100);
      press(1'b1, 1'b1, 10);
      check_val("sat_high_again", 100);
      repeat (9) press(1'b0, 1'b1, 10);
      repeat (7) press(1'b0, 1'b0, 10);
      check_val("value_3", 3);
      press(1'b0, 1'b1, 10);
      check_val("sat_low", 0);
      press(1'b0, 1'b0, 10);
      check_val("sat_low_again", 0);

      pg = 1'b0;
      repeat (10) begin
         up = 1'b0;
         tick($urandom_range(2, 3));
         up = 1'b1;
         tick(3);
      end
      up = 1'b0;
      dn = 1'b0;
      tick(40);
      up = 1'b1;
      dn = 1'b1;
      tick(12);
      check_val("glitch_both", 0);
      check_idle("glitch_model");

      up = 1'b0;
      tick(40);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check_val("reset_mid_repeat", 50);
      checks++;
      if (actualizado !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_strobe got %0b expected 0", actualizado);
      end
      tick(20);
      up = 1'b1;
      tick(15);
      check_idle("after_reset_hold");

      repeat (80) begin
         up = ($urandom_range(0, 2) != 0);
         dn = ($urandom_range(0, 2) != 0);
         pg = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 24) == 0) rst_n = 1'b0;
         tick($urandom_range(1, 40));
         rst_n = 1'b1;
      end
      up = 1'b1;
      dn = 1'b1;
      tick(20);
      check_idle("random_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
